chien_err_addr_collector: RTL and testbench
===========================================

Name: chien_err_addr_collector

Overview:
- Parametrised error-address collector for the BCH decoder.
- Consumes per-cycle PAR-lane root-hit vectors from the parallel Chien search engine, serialises multiple hits within one word, and converts each hit into a codeword bit address.
- Streams the addresses to the correction datapath and reports the error count and a decode-failure flag.
- Generalises the fixed 8-lane/8-error p32 collector in lane count, error capacity, field width and codeword span. Adds a valid/ready handshake, degree check, overflow detection and optional early stop.

Parameters:
- GF_M, 13, field width; address width.
- PAR, 8, Chien lanes evaluated per word.
- T, 8, maximum correctable errors.
- N_START, 4216, address base; word w lane i maps to N_START-1-w*PAR-i.
- N_WORDS, 527, Chien words per codeword; elaboration must fail if N_WORDS*PAR > N_START.
- EARLY_STOP, 0, 1 = finish as soon as err_cnt==deg at a word boundary.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a codeword; sampled only in IDLE
- deg  in  $clog2(T+1)  locator degree from Euclidean; sampled with start
- root_vec  in  PAR  bit i=1: lane i evaluated to zero (root)
- root_valid  in  1  root_vec valid
- root_ready  out  1  collector accepts a word this cycle
- err_valid  out  1  one-cycle strobe, err_addr/err_idx valid
- err_addr  out  GF_M  error bit address
- err_idx  out  $clog2(T)  position of this address in the error list (0-based)
- err_cnt  out  $clog2(T+1)  errors emitted so far
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at end of codeword
- fail  out  1  valid with done and held until the next start; 1 if overflow or err_cnt!=deg

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. On reset:
  - all outputs are 0;
  - state is IDLE;
  - word counter, pending vector and overflow flag are 0.
- A reset mid-operation aborts immediately. No done is produced for the aborted codeword.
- States: IDLE, SCAN, SERIAL, DONE.
- IDLE:
  - root_ready=0; root_valid is ignored.
  - On start: latch deg, clear err_cnt/fail/ovf, set word counter wc=0.
  - If deg==0, go to DONE; otherwise go to SCAN.
- SCAN:
  - root_ready=1, busy=1.
  - On root_valid&root_ready with root_vec==0: wc++. If wc was N_WORDS-1, go to DONE.
  - On a handshake with root_vec!=0: latch it into pend and go to SERIAL. root_ready drops the next cycle.
- SERIAL:
  - root_ready=0.
  - Each cycle, select the lowest set lane i of pend and clear it. If err_cnt<T, assert err_valid with err_addr=N_START-1-wc*PAR-i and err_idx=err_cnt, then increment err_cnt.
  - If err_cnt==T, emit nothing, set sticky ovf and keep clearing bits.
  - When the cleared bit is the last one, wc++ and go to SCAN. Go to DONE instead if wc was N_WORDS-1, or if EARLY_STOP=1 and err_cnt(after update)==deg.
  - A word with k hits holds root_ready low for exactly k cycles.
- DONE:
  - One cycle with done=1 and fail=ovf|(err_cnt!=deg), then return to IDLE.
  - fail and err_cnt hold until the next start.
- Address arithmetic is unsigned, computed from wc*PAR+i, and truncated to GF_M bits. No negative addresses are possible, given the elaboration check.
- start while busy is ignored. start in the DONE cycle is ignored; the upstream must re-pulse it in IDLE.
- Gaps in root_valid (low) in SCAN do not advance wc and do not change state.
- Outputs are registered. err_valid appears 1 cycle after the handshake for the first hit, then once per cycle for each remaining hit.

Test Plan:
- deg=0, start -> done on cycle 2 with fail=0 and err_cnt=0; no root_ready high; no err_valid.
- deg=1, hit lane 0 in word 0, rest of the words zero -> err_addr=4215 with err_idx=0; done after 527 words; fail=0.
- deg=3, word 2 root_vec=8'b1001_0010 -> err_addr 4198, 4195, 4192 on consecutive cycles; root_ready low for exactly 3 cycles; done with fail=0.
- deg=2 but 3 hits in total; separately, T+1=9 hits with deg=8 -> fail=1 in both cases; in the overflow case only 8 err_valid strobes occur and err_cnt=8.
- EARLY_STOP=1, deg=2, hits in words 5 and 10 -> done the cycle after the second hit is serialised; root_ready never high after word 10.
- Reset asserted mid-SERIAL with random root_valid gaps -> all outputs 0 asynchronously; the next start decodes a clean 1-error word correctly.

Source files
------------

// File: rtl/chien_err_addr_collector.sv
// chien_err_addr_collector: serialises parallel Chien root hits into codeword
// bit addresses, counts them and flags decode failure against the locator degree.
module chien_err_addr_collector #(
  parameter int GF_M       = 13,
  parameter int PAR        = 8,
  parameter int T          = 8,
  parameter int N_START    = 4216,
  parameter int N_WORDS    = 527,
  parameter int EARLY_STOP = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [$clog2(T+1)-1:0]   deg,
  input  logic [PAR-1:0]           root_vec,
  input  logic                     root_valid,
  output logic                     root_ready,
  output logic                     err_valid,
  output logic [GF_M-1:0]          err_addr,
  output logic [$clog2(T)-1:0]     err_idx,
  output logic [$clog2(T+1)-1:0]   err_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);
  localparam int DW = $clog2(T+1);
  localparam int IW = $clog2(T);
  localparam int WW = $clog2(N_WORDS);
  localparam int LW = PAR > 1 ? $clog2(PAR) : 1;

  if (N_WORDS*PAR > N_START) begin : g_bad_span
    $error("N_WORDS*PAR exceeds N_START");
  end

  typedef enum logic [1:0] {IDLE, SCAN, SERIAL, DONE} state_t;
  state_t state, state_n;

  logic [WW-1:0]   wc;
  logic [PAR-1:0]  pend, pend_rest;
  logic [DW-1:0]   deg_q, cnt_n;
  logic [LW-1:0]   lane;
  logic [GF_M-1:0] addr_n;
  logic            ovf, fail_q, emit, last_word, fail_now;

  assign root_ready = state == SCAN;
  assign busy       = state == SCAN || state == SERIAL;
  assign done       = state == DONE;
  assign fail_now   = ovf || err_cnt != deg_q;
  assign fail       = done ? fail_now : fail_q;

  always_comb begin
    lane = '0;
    for (int k = PAR-1; k >= 0; k--) if (pend[k]) lane = LW'(k);
    pend_rest = pend & (pend - PAR'(1));
    emit      = err_cnt < DW'(T);
    cnt_n     = err_cnt + DW'(emit);
    last_word = wc == WW'(N_WORDS-1);
    addr_n    = GF_M'(N_START - 1 - int'(wc)*PAR - int'(lane));
    state_n   = state;
    case (state)
      IDLE:   if (start) state_n = deg == '0 ? DONE : SCAN;
      SCAN:   if (root_valid) state_n = root_vec != '0 ? SERIAL : last_word ? DONE : SCAN;
      SERIAL: if (pend_rest == '0)
                state_n = (last_word || (EARLY_STOP != 0 && cnt_n == deg_q)) ? DONE : SCAN;
      DONE:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wc        <= '0;
      pend      <= '0;
      deg_q     <= '0;
      ovf       <= 1'b0;
      fail_q    <= 1'b0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_idx   <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      err_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          deg_q   <= deg;
          err_cnt <= '0;
          fail_q  <= 1'b0;
          ovf     <= 1'b0;
          wc      <= '0;
        end
        SCAN: if (root_valid) begin
          if (root_vec != '0) pend <= root_vec;
          else wc <= wc + WW'(1);
        end
        SERIAL: begin
          pend <= pend_rest;
          // Past T hits the list is full: drop the address and remember the overflow.
          if (emit) begin
            err_valid <= 1'b1;
            err_addr  <= addr_n;
            err_idx   <= IW'(err_cnt);
            err_cnt   <= cnt_n;
          end else ovf <= 1'b1;
          if (pend_rest == '0) wc <= wc + WW'(1);
        end
        DONE: fail_q <= fail_now;
      endcase
    end
  end
endmodule

// File: tb/tb_chien_err_addr_collector.sv
// tb_chien_err_addr_collector: randomized codeword scenarios checked against a
// list-based model of which addresses a decoder should report.
module tb_chien_err_addr_collector;
  localparam int GF_M = 13, PAR = 8, T = 8, N_START = 4216, N_WORDS = 527;

  logic clk = 0, rstn = 0, start_a = 0, start_b = 0, root_valid = 0, sel = 0;
  logic [3:0] deg = '0;
  logic [7:0] root_vec = '0;
  logic rr_a, ev_a, busy_a, done_a, fail_a, rr_b, ev_b, busy_b, done_b, fail_b;
  logic [12:0] addr_a, addr_b;
  logic [2:0] idx_a, idx_b;
  logic [3:0] cnt_a, cnt_b;

  chien_err_addr_collector #(.EARLY_STOP(0)) dut (
    .clk(clk), .rstn(rstn), .start(start_a), .deg(deg), .root_vec(root_vec),
    .root_valid(root_valid), .root_ready(rr_a), .err_valid(ev_a), .err_addr(addr_a),
    .err_idx(idx_a), .err_cnt(cnt_a), .busy(busy_a), .done(done_a), .fail(fail_a));

  chien_err_addr_collector #(.EARLY_STOP(1)) dut_es (
    .clk(clk), .rstn(rstn), .start(start_b), .deg(deg), .root_vec(root_vec),
    .root_valid(root_valid), .root_ready(rr_b), .err_valid(ev_b), .err_addr(addr_b),
    .err_idx(idx_b), .err_cnt(cnt_b), .busy(busy_b), .done(done_b), .fail(fail_b));

  wire rr = sel ? rr_b : rr_a, ev = sel ? ev_b : ev_a, busy = sel ? busy_b : busy_a;
  wire done = sel ? done_b : done_a, fail = sel ? fail_b : fail_a;
  wire [12:0] eaddr = sel ? addr_b : addr_a;
  wire [2:0] eidx = sel ? idx_b : idx_a;
  wire [3:0] cnt = sel ? cnt_b : cnt_a;

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [7:0] words [N_WORDS];
  int obs_addr[$], obs_idx[$], exp_addr[$];
  int obs_fail, obs_cnt, obs_words, obs_stall, obs_rr, obs_cyc;
  int exp_fail, exp_cnt, exp_words, exp_stall;
  bit to;

  task automatic clear_words();
    foreach (words[w]) words[w] = '0;
  endtask

  task automatic set_hit(input int w, input int l);
    words[w][l] = 1'b1;
  endtask

  // Walk the codeword in address order, keeping the first T hits.
  task automatic model(input int dg, input bit es);
    int em = 0;
    bit ov = 0;
    exp_addr.delete();
    exp_words = 0;
    exp_stall = 0;
    if (dg != 0)
      for (int w = 0; w < N_WORDS; w++) begin
        exp_words = w + 1;
        for (int i = 0; i < PAR; i++)
          if (words[w][i]) begin
            exp_stall++;
            if (em < T) begin exp_addr.push_back(N_START - 1 - w*PAR - i); em++; end
            else ov = 1;
          end
        if (es && words[w] != 0 && em == dg) break;
      end
    exp_fail = int'(ov || em != dg);
    exp_cnt = em;
  endtask

  task automatic run(input int dg, input bit es, input int gap, input bit stop_serial);
    int wi = 0;
    obs_addr.delete(); obs_idx.delete();
    obs_stall = 0; obs_rr = 0; obs_cyc = -1; obs_fail = -1; obs_cnt = -1;
    to = 1;
    sel = es;
    @(negedge clk);
    deg = 4'(dg);
    if (es) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0; start_b = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ev) begin obs_addr.push_back(int'(eaddr)); obs_idx.push_back(int'(eidx)); end
      if (busy && !rr) obs_stall++;
      if (rr) obs_rr++;
      if (done) begin obs_fail = int'(fail); obs_cnt = int'(cnt); obs_cyc = c; to = 0; break; end
      if (stop_serial && busy && !rr) begin to = 0; break; end
      root_valid = wi < N_WORDS && $urandom_range(99) >= gap;
      root_vec = words[wi < N_WORDS ? wi : 0];
      if (root_valid && rr) wi++;
      @(negedge clk);
    end
    root_valid = 0;
    obs_words = wi;
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rr_a, ev_a, addr_a, idx_a, cnt_a, busy_a, done_a, fail_a} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %h required 0",
        {rr_a, ev_a, addr_a, idx_a, cnt_a, busy_a, done_a, fail_a});
    end
    rstn = 1;
  endtask

  task automatic test_deg0();
    clear_words();
    set_hit(0, 3);
    run(0, 0, 0, 0);
    n_cmp++;
    if (to || obs_cyc != 0 || obs_fail != 0 || obs_cnt != 0) begin
      n_fail++; $display("FAIL deg0 done: to=%0d cyc=%0d fail=%0d cnt=%0d required cyc=0 fail=0 cnt=0",
        to, obs_cyc, obs_fail, obs_cnt);
    end
    n_cmp++;
    if (obs_rr != 0 || obs_addr.size() != 0) begin
      n_fail++; $display("FAIL deg0 quiet: ready_cycles=%0d strobes=%0d required 0/0", obs_rr, obs_addr.size());
    end
  endtask

  // Shared shape of a full-codeword comparison, written out per scenario.
  task automatic test_single();
    clear_words();
    set_hit(0, 0);
    run(1, 0, 0, 0);
    model(1, 0);
    n_cmp++;
    if (to || obs_fail != exp_fail || obs_cnt != exp_cnt || obs_words != exp_words) begin
      n_fail++; $display("FAIL single status: to=%0d fail=%0d cnt=%0d words=%0d required fail=%0d cnt=%0d words=%0d",
        to, obs_fail, obs_cnt, obs_words, exp_fail, exp_cnt, exp_words);
    end
    n_cmp++;
    if (obs_addr.size() != 1 || obs_addr[0] != 4215 || obs_idx[0] != 0) begin
      n_fail++; $display("FAIL single addr: n=%0d addr=%0d required n=1 addr=4215 idx=0",
        obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1);
    end
  endtask

  task automatic test_multi_hit();
    clear_words();
    words[2] = 8'b1001_0010;
    run(3, 0, 25, 0);
    model(3, 0);
    n_cmp++;
    if (to || obs_fail != 0 || obs_cnt != 3 || obs_stall != 3) begin
      n_fail++; $display("FAIL multi status: to=%0d fail=%0d cnt=%0d stall=%0d required fail=0 cnt=3 stall=3",
        to, obs_fail, obs_cnt, obs_stall);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_addr.size() != 3 || obs_addr[k] != exp_addr[k] || obs_idx[k] != k) begin
        n_fail++; $display("FAIL multi addr[%0d]: got %0d idx %0d required %0d idx %0d", k,
          k < obs_addr.size() ? obs_addr[k] : -1, k < obs_idx.size() ? obs_idx[k] : -1, exp_addr[k], k);
      end
    end
  endtask

  task automatic test_fail();
    clear_words();
    set_hit(4, 2); set_hit(100, 7); set_hit(526, 0);
    run(2, 0, 10, 0);
    model(2, 0);
    n_cmp++;
    if (to || obs_fail != 1 || obs_cnt != 3 || obs_addr != exp_addr) begin
      n_fail++; $display("FAIL deg mismatch: to=%0d fail=%0d cnt=%0d required fail=1 cnt=3", to, obs_fail, obs_cnt);
    end
    clear_words();
    words[1] = 8'hF0; words[3] = 8'h0F; set_hit(200, 5);
    run(8, 0, 10, 0);
    model(8, 0);
    n_cmp++;
    if (to || obs_fail != 1 || obs_cnt != 8 || obs_addr.size() != 8 || obs_stall != 9) begin
      n_fail++; $display("FAIL overflow: to=%0d fail=%0d cnt=%0d strobes=%0d stall=%0d required 1/8/8/9",
        to, obs_fail, obs_cnt, obs_addr.size(), obs_stall);
    end
    n_cmp++;
    if (obs_addr != exp_addr) begin
      n_fail++; $display("FAIL overflow addrs: first got %0d required %0d", obs_addr[0], exp_addr[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (fail_a !== 1'b1 || cnt_a !== 4'd8 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL hold after done: fail=%0d cnt=%0d done=%0d required 1/8/0", fail_a, cnt_a, done_a);
    end
  endtask

  task automatic test_early_stop();
    clear_words();
    set_hit(5, $urandom_range(7)); set_hit(10, $urandom_range(7)); set_hit(300, 1);
    run(2, 1, 20, 0);
    model(2, 1);
    n_cmp++;
    if (to || obs_fail != 0 || obs_cnt != 2 || obs_words != 11 || obs_stall != 2) begin
      n_fail++; $display("FAIL early stop: to=%0d fail=%0d cnt=%0d words=%0d stall=%0d required 0/2/11/2",
        to, obs_fail, obs_cnt, obs_words, obs_stall);
    end
    n_cmp++;
    if (obs_addr != exp_addr) begin
      n_fail++; $display("FAIL early stop addrs: n=%0d required n=%0d", obs_addr.size(), exp_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int w, l;
    clear_words();
    words[0] = 8'hFF; words[1] = 8'hFF;
    run(8, 0, 30, 1);
    #2 rstn = 0;
    #1;
    n_cmp++;
    if (to || {rr_a, ev_a, addr_a, idx_a, cnt_a, busy_a, done_a, fail_a} !== '0) begin
      n_fail++; $display("FAIL reset mid serial: to=%0d outputs %h required 0", to,
        {rr_a, ev_a, addr_a, idx_a, cnt_a, busy_a, done_a, fail_a});
    end
    @(negedge clk);
    rstn = 1;
    clear_words();
    w = $urandom_range(N_WORDS-1); l = $urandom_range(PAR-1);
    set_hit(w, l);
    run(1, 0, 30, 0);
    model(1, 0);
    n_cmp++;
    if (to || obs_fail != 0 || obs_cnt != 1 || obs_addr != exp_addr) begin
      n_fail++; $display("FAIL post reset decode: to=%0d fail=%0d cnt=%0d addr=%0d required 0/1/%0d",
        to, obs_fail, obs_cnt, obs_addr.size() ? obs_addr[0] : -1, exp_addr[0]);
    end
  endtask

  task automatic test_random();
    int dg;
    for (int it = 0; it < 5; it++) begin
      clear_words();
      for (int h = $urandom_range(11); h > 0; h--) set_hit($urandom_range(N_WORDS-1), $urandom_range(PAR-1));
      dg = $urandom_range(8, 1);
      run(dg, 0, $urandom_range(40), 0);
      model(dg, 0);
      n_cmp++;
      if (to || obs_fail != exp_fail || obs_cnt != exp_cnt || obs_stall != exp_stall || obs_words != exp_words) begin
        n_fail++; $display("FAIL random %0d status: to=%0d fail=%0d cnt=%0d stall=%0d words=%0d required %0d/%0d/%0d/%0d",
          it, to, obs_fail, obs_cnt, obs_stall, obs_words, exp_fail, exp_cnt, exp_stall, exp_words);
      end
      n_cmp++;
      if (obs_addr != exp_addr) begin
        n_fail++; $display("FAIL random %0d addrs: n=%0d required n=%0d", it, obs_addr.size(), exp_addr.size());
      end
      for (int k = 0; k < obs_idx.size(); k++) begin
        n_cmp++;
        if (obs_idx[k] != k) begin
          n_fail++; $display("FAIL random %0d idx[%0d]: got %0d required %0d", it, k, obs_idx[k], k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_deg0();
    test_single();
    test_multi_hit();
    test_fail();
    test_early_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
